// File: rtl/rotate_addr_gen.sv
// Inverse-rotation source address generator for the block pixel reader.
// Walks the output raster and emits clamped source coordinates into the address FIFO.
module rotate_addr_gen #(
    parameter logic [10:0] FRAME_X = 11'd1920,
    parameter logic [10:0] FRAME_Y = 11'd1080,
    parameter int          FRAC    = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] cos_val,
    input  logic [15:0] sin_val,
    input  logic [1:0]  frame_index_in,
    input  logic        addr_wr_almost_full,
    output logic [10:0] addr_x,
    output logic [10:0] addr_y,
    output logic [1:0]  base_addr_index,
    output logic        addr_wr_en,
    output logic        addr_oob,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;

    localparam logic signed [31:0] CX   = 32'(FRAME_X >> 1);
    localparam logic signed [31:0] CY   = 32'(FRAME_Y >> 1);
    localparam logic signed [31:0] FX   = 32'(FRAME_X);
    localparam logic signed [31:0] FY   = 32'(FRAME_Y);
    localparam logic signed [31:0] HALF = 32'sd1 <<< (FRAC - 1);

    state_t             state;
    logic [15:0]        cos_r, sin_r;
    logic signed [31:0] xr, yr, x, y;
    logic [10:0]        u, v;

    logic signed [31:0] cos_w, sin_w, x0, y0;
    logic signed [31:0] xi, yi, xr_n, yr_n;
    logic [10:0]        x_cl, y_cl;
    logic               oob;

    assign cos_w = {{16{cos_r[15]}}, cos_r};
    assign sin_w = {{16{sin_r[15]}}, sin_r};

    // Once-per-frame start point: rotate the (0,0) output pixel about the centre
    assign x0 = (CX <<< FRAC) - cos_w * CX - sin_w * CY;
    assign y0 = (CY <<< FRAC) + sin_w * CX - cos_w * CY;

    assign xr_n = xr + sin_w;
    assign yr_n = yr + cos_w;

    assign xi = (x + HALF) >>> FRAC;
    assign yi = (y + HALF) >>> FRAC;

    always_comb begin
        x_cl = xi[10:0];
        y_cl = yi[10:0];
        if (xi < 0)
            x_cl = '0;
        else if (xi >= FX)
            x_cl = FRAME_X - 11'd1;
        if (yi < 0)
            y_cl = '0;
        else if (yi >= FY)
            y_cl = FRAME_Y - 11'd1;
        oob = (xi < 0) | (xi >= FX) | (yi < 0) | (yi >= FY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cos_r           <= '0;
            sin_r           <= '0;
            xr              <= '0;
            yr              <= '0;
            x               <= '0;
            y               <= '0;
            u               <= '0;
            v               <= '0;
            addr_x          <= '0;
            addr_y          <= '0;
            base_addr_index <= '0;
            addr_wr_en      <= 1'b0;
            addr_oob        <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            addr_wr_en <= 1'b0;
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A start coinciding with the frame_done pulse is dropped
                    if (start && !frame_done) begin
                        cos_r           <= cos_val;
                        sin_r           <= sin_val;
                        base_addr_index <= frame_index_in;
                        busy            <= 1'b1;
                        state           <= INIT;
                    end
                end
                INIT: begin
                    xr    <= x0;
                    x     <= x0;
                    yr    <= y0;
                    y     <= y0;
                    u     <= '0;
                    v     <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (!addr_wr_almost_full) begin
                        addr_x     <= x_cl;
                        addr_y     <= y_cl;
                        addr_oob   <= oob;
                        addr_wr_en <= 1'b1;
                        if (u == FRAME_X - 11'd1) begin
                            u <= '0;
                            if (v == FRAME_Y - 11'd1) begin
                                state <= DONE;
                            end else begin
                                v  <= v + 11'd1;
                                xr <= xr_n;
                                x  <= xr_n;
                                yr <= yr_n;
                                y  <= yr_n;
                            end
                        end else begin
                            u <= u + 11'd1;
                            x <= x + cos_w;
                            y <= y - sin_w;
                        end
                    end
                end
                DONE: begin
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_addr_gen.sv
// Bench for rotate_addr_gen on an 8x4 frame: vector table, corner sequences
// and randomized frames against a closed-form rotation model.
module tb_rotate_addr_gen;

    localparam logic [10:0] FX = 11'd8;
    localparam logic [10:0] FY = 11'd4;
    localparam int NPIX = 32;
    localparam int CXM  = 4;
    localparam int CYM  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cos_val = '0;
    logic [15:0] sin_val = '0;
    logic [1:0]  frame_index_in = '0;
    logic        af = 1'b0;
    logic [10:0] addr_x, addr_y;
    logic [1:0]  base_addr_index;
    logic        addr_wr_en, addr_oob, busy, frame_done;

    rotate_addr_gen #(.FRAME_X(FX), .FRAME_Y(FY), .FRAC(14)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .start               (start),
        .cos_val             (cos_val),
        .sin_val             (sin_val),
        .frame_index_in      (frame_index_in),
        .addr_wr_almost_full (af),
        .addr_x              (addr_x),
        .addr_y              (addr_y),
        .base_addr_index     (base_addr_index),
        .addr_wr_en          (addr_wr_en),
        .addr_oob            (addr_oob),
        .busy                (busy),
        .frame_done          (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        int s;
        int k;
        int ex;
        int ey;
        int eo;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int wx[64], wy[64], wo[64], wc[64];
    int nw, nd, idx_bad, extra, post_busy, done_cyc;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    // Source coordinate of output pixel (u,v), rotated about the centre
    function automatic int model(input int c, input int s, input int k);
        longint x, y, xi, yi;
        int u, v, ex, ey, eo;
        u  = k % int'(FX);
        v  = k / int'(FX);
        x  = (longint'(CXM) <<< 14) + longint'(c) * longint'(u - CXM)
           + longint'(s) * longint'(v - CYM);
        y  = (longint'(CYM) <<< 14) - longint'(s) * longint'(u - CXM)
           + longint'(c) * longint'(v - CYM);
        xi = (x + 8192) >>> 14;
        yi = (y + 8192) >>> 14;
        eo = (xi < 0 || xi >= longint'(FX) || yi < 0 || yi >= longint'(FY)) ? 1 : 0;
        ex = xi < 0 ? 0 : (xi >= longint'(FX) ? int'(FX) - 1 : int'(xi));
        ey = yi < 0 ? 0 : (yi >= longint'(FY) ? int'(FY) - 1 : int'(yi));
        return ex * 4096 + ey * 2 + eo;
    endfunction

    // mode: 0 plain, 1 random backpressure, 2 hold 5 cycles at pixel 10,
    // 3 extra start at write 5, 4 start during frame_done
    task automatic run_frame(input int c, input int s, input int idx, input int mode);
        int cyc, hold;
        nw = 0; nd = 0; idx_bad = 0; hold = 0;
        extra = 0; post_busy = 0; done_cyc = 0;
        @(negedge clk);
        start = 1'b1;
        cos_val = 16'(c);
        sin_val = 16'(s);
        frame_index_in = 2'(idx);
        @(negedge clk);
        start = 1'b0;
        cos_val = 16'($urandom);
        sin_val = 16'($urandom);
        frame_index_in = 2'($urandom);
        cyc = 0;
        while (nd == 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (addr_wr_en) begin
                if (nw < 64) begin
                    wx[nw] = int'(addr_x);
                    wy[nw] = int'(addr_y);
                    wo[nw] = int'(addr_oob);
                    wc[nw] = cyc;
                end
                if (base_addr_index != 2'(idx))
                    idx_bad++;
                nw++;
                if (mode == 3 && nw == 5) begin
                    start = 1'b1;
                    cos_val = 16'(-16384);
                    sin_val = 16'(5000);
                    frame_index_in = 2'(idx + 1);
                end
            end
            if (frame_done) begin
                nd++;
                done_cyc = cyc;
                if (mode == 4)
                    start = 1'b1;
            end
            if (mode == 1) begin
                af = ($urandom_range(0, 3) == 0);
            end else if (mode == 2) begin
                if (nw == 10 && hold < 5) begin
                    af = 1'b1;
                    hold++;
                end else begin
                    af = 1'b0;
                end
            end
        end
        af = 1'b0;
        if (nd == 0)
            chk("frame_timeout", 0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (addr_wr_en || frame_done)
                extra++;
            if (busy)
                post_busy++;
        end
    endtask

    task automatic check_frame(input int c, input int s);
        chk("count", nw, NPIX);
        chk("frame_done_cnt", nd, 1);
        chk("base_idx", idx_bad, 0);
        chk("after_done", extra + post_busy, 0);
        for (int k = 0; k < NPIX; k++)
            chk($sformatf("pix%0d", k),
                wx[k] * 4096 + wy[k] * 2 + wo[k], model(c, s, k));
    endtask

    initial begin
        vec_t tbl[9];
        int n, cyc, bad, c, s, idx;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_addr_x", int'(addr_x), 0);
        chk("rst_addr_y", int'(addr_y), 0);
        chk("rst_idx", int'(base_addr_index), 0);
        chk("rst_wr_en", int'(addr_wr_en), 0);
        chk("rst_oob", int'(addr_oob), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(frame_done), 0);
        rst_n = 1'b1;

        tbl[0] = '{16384, 0, 0, 0, 0, 0};
        tbl[1] = '{16384, 0, 10, 2, 1, 0};
        tbl[2] = '{16384, 0, 31, 7, 3, 0};
        tbl[3] = '{-16384, 0, 0, 7, 3, 1};
        tbl[4] = '{-16384, 0, 1, 7, 3, 1};
        tbl[5] = '{-16384, 0, 9, 7, 3, 0};
        tbl[6] = '{0, 16384, 0, 2, 3, 1};
        tbl[7] = '{0, 16384, 20, 4, 2, 0};
        tbl[8] = '{0, 16384, 31, 5, 0, 1};
        foreach (tbl[i]) begin
            run_frame(tbl[i].c, tbl[i].s, 2, 0);
            chk($sformatf("tbl%0d_count", i), nw, NPIX);
            chk($sformatf("tbl%0d_x", i), wx[tbl[i].k], tbl[i].ex);
            chk($sformatf("tbl%0d_y", i), wy[tbl[i].k], tbl[i].ey);
            chk($sformatf("tbl%0d_oob", i), wo[tbl[i].k], tbl[i].eo);
            chk($sformatf("tbl%0d_idx", i), idx_bad, 0);
        end

        run_frame(16384, 0, 2, 0);
        check_frame(16384, 0);
        chk("first_latency", wc[0], 2);
        chk("done_latency", done_cyc - wc[NPIX - 1], 1);
        chk("no_bubble_wrap", wc[8] - wc[7], 1);

        run_frame(16384, 0, 1, 2);
        check_frame(16384, 0);
        chk("bp_gap", wc[10] - wc[9], 6);
        chk("bp_resume", wx[10] * 4096 + wy[10], 2 * 4096 + 1);

        run_frame(16384, 0, 2, 3);
        check_frame(16384, 0);

        run_frame(16384, 0, 3, 4);
        chk("start_on_done_busy", post_busy, 0);
        chk("start_on_done_wr", extra, 0);

        for (int r = 0; r < 20; r++) begin
            c = int'($urandom_range(0, 32768)) - 16384;
            s = int'($urandom_range(0, 32768)) - 16384;
            idx = int'($urandom_range(0, 3));
            run_frame(c, s, idx, 1);
            check_frame(c, s);
        end

        @(negedge clk);
        start = 1'b1;
        cos_val = 16'd16384;
        sin_val = 16'd0;
        frame_index_in = 2'd1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 12 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (addr_wr_en)
                n++;
        end
        chk("rst_reach12", n, 12);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_x", int'(addr_x), 0);
        chk("midrst_y", int'(addr_y), 0);
        chk("midrst_idx", int'(base_addr_index), 0);
        chk("midrst_wr", int'(addr_wr_en), 0);
        chk("midrst_oob", int'(addr_oob), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(frame_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (addr_wr_en || busy || frame_done)
                bad++;
        end
        chk("idle_after_rst", bad, 0);
        run_frame(16384, 0, 0, 0);
        check_frame(16384, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rotate_addr_gen.md
Name: rotate_addr_gen

Overview:
- Upstream address source for the block pixel reader.
- For every output pixel in raster order, computes the inverse-rotated source coordinate (addr_x, addr_y) about the frame centre and pushes it into the reader's address FIFO under almost-full backpressure.
- Uses incremental fixed-point accumulation, so there are no per-pixel multipliers. Multipliers are used once per frame, in INIT.
- Flags coordinates that fall outside the source frame so the pixel output path can blank them.

Parameters:
- FRAME_X, 11'd1920, frame width in pixels; also the output raster width.
- FRAME_Y, 11'd1080, frame height in pixels; also the output raster height.
- FRAC, 14, fractional bits of cos_val and sin_val (Q1.14).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle pulse; begins one frame of address generation.
- cos_val  in  16  signed Q1.14 cosine of the rotation angle; sampled on an accepted start.
- sin_val  in  16  signed Q1.14 sine of the rotation angle; sampled on an accepted start.
- frame_index_in  in  2  source frame-buffer index; sampled on an accepted start.
- addr_wr_almost_full  in  1  backpressure from the reader's address FIFO.
- addr_x  out  11  source x coordinate, clamped to 0..FRAME_X-1.
- addr_y  out  11  source y coordinate, clamped to 0..FRAME_Y-1.
- base_addr_index  out  2  latched frame_index_in; constant for the whole frame.
- addr_wr_en  out  1  one-cycle write strobe for {addr_x, addr_y}.
- addr_oob  out  1  high with addr_wr_en when the unclamped coordinate lay outside the frame.
- busy  out  1  high from an accepted start until frame_done.
- frame_done  out  1  one-cycle pulse after the last address is written.

Behaviour:
- Clock and reset: single clock, clk. rst_n is asynchronous, active-low. While rst_n is low, all outputs and all state are 0 and the FSM is in IDLE. Reset mid-frame aborts the frame; no further addr_wr_en is issued.
- Centre: cx = FRAME_X/2, cy = FRAME_Y/2 (integer).
- Accumulators: signed 32-bit in Q.FRAC format.
  - Row-start pair: xr, yr.
  - Pixel pair: x, y.
- FSM states: IDLE, INIT, RUN, DONE.
- IDLE:
  - On start, latch cos_val, sin_val and frame_index_in, set busy=1, go to INIT.
  - start while busy=1 is ignored.
- INIT (1 cycle):
  - xr = x = (cx<<FRAC) - cos*cx - sin*cy.
  - yr = y = (cy<<FRAC) + sin*cx - cos*cy.
  - Clear column counter u and row counter v. Go to RUN.
- RUN, each cycle:
  - If addr_wr_almost_full=1: addr_wr_en=0, and accumulators and counters hold.
  - Otherwise, issue one address (output register rules below), then advance.
- Output register, on each issued address:
  - xi = (x + 2^(FRAC-1)) >>> FRAC, i.e. round half-up with arithmetic shift; yi likewise.
  - addr_oob = (xi<0) | (xi>=FRAME_X) | (yi<0) | (yi>=FRAME_Y).
  - addr_x = xi clamped to 0 or FRAME_X-1; addr_y = yi clamped likewise.
  - addr_wr_en=1.
- Advance, within a row (u<FRAME_X-1): x += cos, y -= sin, u++.
- Advance, at row end (u=FRAME_X-1):
  - xr += sin, yr += cos; x = xr+sin, y = yr+cos (the new row-start values); u=0, v++.
  - If also v=FRAME_Y-1, go to DONE instead.
- Throughput: one address per clock when not backpressured; no bubble at row wrap.
- DONE (1 cycle): frame_done=1, busy=0, addr_wr_en=0, go to IDLE.
- Latency:
  - First addr_wr_en 2 cycles after start (start → INIT → RUN, registered output).
  - frame_done 1 cycle after the last addr_wr_en.
- Count: exactly FRAME_X*FRAME_Y addr_wr_en pulses per frame.
- Backpressure: almost_full is sampled on the same cycle the write is decided. The FIFO's almost-full margin absorbs the one registered write in flight.
- Simultaneous start and frame_done (DONE cycle): start is ignored; it is accepted only in IDLE.
- Input stability: changes to cos_val, sin_val or frame_index_in during a frame have no effect.
- Outputs addr_x, addr_y, addr_oob hold their last values when addr_wr_en=0.

Test Plan:
- Identity, defaults, cos=16384, sin=0, index=2 → 2073600 pulses; addresses (0,0),(1,0)…(1919,0),(0,1)…(1919,1079); addr_oob always 0; base_addr_index=2; frame_done once.
- 180°, FRAME_X=8, FRAME_Y=4, cos=-16384, sin=0 → first write xi=8 clamped to 7, yi=4 clamped to 3, oob=1. Second write (7,3) oob=1. Row v=1, u=1 → (7,3) oob=0.
- 90°, FRAME_X=8, FRAME_Y=4, cos=0, sin=16384 → u=0,v=0: y=6 clamped to 3, oob=1. u=4,v=2: (4,2) oob=0. 32 pulses total.
- Backpressure: identity, 8x4; hold almost_full=1 for 5 cycles at pixel 10 → no writes for those 5 cycles; sequence resumes at (2,1) with no skip or duplicate; 32 pulses total.
- Reset mid-frame: deassert rst_n after 12 writes → all outputs 0 immediately. After release, no writes until the next start; the new frame starts at (0,0).
- Start while busy: pulse start at write 5 with different cos/sin/index → ignored; frame completes with the original values and a single frame_done.
